// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), line/frame total helpers and the
// scan-counter type used by vga_sync_counter and vga_scan_fetch.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Largest line or frame total the counters must hold.
  localparam int MAX_TOTAL = 4096;
  localparam int CNT_W     = $clog2(MAX_TOTAL);

  typedef logic [CNT_W-1:0] cnt_t;

  // Per-position control bits carried down the alignment pipe.
  typedef struct packed {
    logic active;
    logic rd;
    logic hs;
    logic vs;
    logic odd;
    logic fstart;
    logic tp;
  } ctl_t;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical scan counters with active-region and sync-region decode.
// Sync flags are active-high; polarity is applied by the consumer.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst,
  output cnt_t h,
  output cnt_t v,
  output logic active,
  output logic hsync_on,
  output logic vsync_on
);

  localparam int   HT     = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   VT     = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam cnt_t H_LAST = cnt_t'(HT - 1);
  localparam cnt_t V_LAST = cnt_t'(VT - 1);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  always_comb begin
    h_d = h_q + cnt_t'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h        = h_q;
  assign v        = v_q;
  assign active   = (h_q < cnt_t'(H_ACTIVE)) && (v_q < cnt_t'(V_ACTIVE));
  assign hsync_on = (h_q >= cnt_t'(H_ACTIVE + H_FP)) &&
                    (h_q <  cnt_t'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_on = (v_q >= cnt_t'(V_ACTIVE + V_FP)) &&
                    (v_q <  cnt_t'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_scan_fetch.sv
// VGA scan-out: timing, linear frame-buffer fetch, word unpack and output alignment.
// Optional test pattern source enabled by defining VGA_SCAN_TESTPAT_EN.
module vga_scan_fetch
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_W    = 8,
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int MEM_LAT  = 1
) (
  input  logic              vid_clk,
  input  logic              vid_rst,
  input  logic [ADDR_W-1:0] frame_base,
`ifdef VGA_SCAN_TESTPAT_EN
  input  logic              testpat_sel,
`endif
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  output logic [PIX_W-1:0]  pixel,
  output logic              hsync,
  output logic              vsync,
  output logic              vid_blank,
  output logic              oddeven,
  output logic              frame_start
);

  localparam int PPW = WORD_W / PIX_W;
  localparam int KW  = (PPW > 1) ? $clog2(PPW) : 1;

  cnt_t h, v, hm;
  logic active, hs_on, vs_on, first_s, tp_s;

  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_sync (
    .clk      (vid_clk),
    .rst      (vid_rst),
    .h        (h),
    .v        (v),
    .active   (active),
    .hsync_on (hs_on),
    .vsync_on (vs_on)
  );

  // Fetch stage: registered read request for the current counter position.
  logic                      mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]         addr_ptr_q, addr_ptr_d;
  ctl_t                      ctl_s;
  ctl_t [MEM_LAT:0]          ctl_q, ctl_d;
  logic [MEM_LAT:0][KW-1:0]  k_q, k_d;

  // Unpack/output stage.
  ctl_t              ctl_o;
  logic [KW-1:0]     k_o;
  logic [WORD_W-1:0] word_q, word_d;
  logic [PIX_W-1:0]  tpx_o;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              blank_q, blank_d, odd_q, odd_d, fs_q, fs_d;

`ifdef VGA_SCAN_TESTPAT_EN
  logic                        tp_q, tp_d;
  logic [7:0]                  hv8;
  logic [MEM_LAT:0][PIX_W-1:0] tpx_q, tpx_d;

  // Pattern select is latched at the frame origin so a frame is never mixed.
  always_comb begin
    tp_d  = first_s ? testpat_sel : tp_q;
    hv8   = 8'(h ^ v);
    tpx_d = {tpx_q[MEM_LAT-1:0], PIX_W'(hv8)};
  end

  always_ff @(posedge vid_clk) begin
    if (vid_rst) begin
      tp_q  <= 1'b0;
      tpx_q <= '0;
    end else begin
      tp_q  <= tp_d;
      tpx_q <= tpx_d;
    end
  end

  assign tp_s  = tp_d;
  assign tpx_o = tpx_q[MEM_LAT];
`else
  assign tp_s  = 1'b0;
  assign tpx_o = '0;
`endif

  always_comb begin
    first_s    = (h == '0) && (v == '0);
    hm         = h & cnt_t'(PPW - 1);
    mem_rd_d   = active && (hm == '0) && !tp_s;
    mem_addr_d = first_s ? frame_base : addr_ptr_q;
    addr_ptr_d = mem_addr_d;
    if (mem_rd_d) addr_ptr_d = mem_addr_d + ADDR_W'(1);

    ctl_s        = '0;
    ctl_s.active = active;
    ctl_s.rd     = mem_rd_d;
    ctl_s.hs     = hs_on;
    ctl_s.vs     = vs_on;
    ctl_s.odd    = v[0];
    ctl_s.fstart = first_s;
    ctl_s.tp     = tp_s;
    ctl_d        = {ctl_q[MEM_LAT-1:0], ctl_s};
    k_d          = {k_q[MEM_LAT-1:0], hm[KW-1:0]};
  end

  // Slot MEM_LAT of the pipe lines up with the cycle its read data is valid.
  always_comb begin
    ctl_o  = ctl_q[MEM_LAT];
    k_o    = k_q[MEM_LAT];
    word_d = word_q;
    if (ctl_o.rd) word_d = mem_data;
    pixel_d = '0;
    if (ctl_o.active) begin
      pixel_d = ctl_o.tp ? tpx_o : PIX_W'(word_d >> (int'(k_o) * PIX_W));
    end
    hsync_d = ctl_o.hs ? SYNC_POL : !SYNC_POL;
    vsync_d = ctl_o.vs ? SYNC_POL : !SYNC_POL;
    blank_d = ctl_o.active;
    odd_d   = ctl_o.odd;
    fs_d    = ctl_o.fstart;
  end

  always_ff @(posedge vid_clk) begin
    if (vid_rst) begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      addr_ptr_q <= '0;
      ctl_q      <= '0;
      k_q        <= '0;
      word_q     <= '0;
      pixel_q    <= '0;
      hsync_q    <= !SYNC_POL;
      vsync_q    <= !SYNC_POL;
      blank_q    <= 1'b0;
      odd_q      <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      addr_ptr_q <= addr_ptr_d;
      ctl_q      <= ctl_d;
      k_q        <= k_d;
      word_q     <= word_d;
      pixel_q    <= pixel_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      blank_q    <= blank_d;
      odd_q      <= odd_d;
      fs_q       <= fs_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign pixel       = pixel_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vid_blank   = blank_q;
  assign oddeven     = odd_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_fetch.sv
// Directed bench for vga_scan_fetch on a reduced 24x8 raster, 4-bit pixels, MEM_LAT=3.
// Define VGA_SCAN_TESTPAT_EN to also exercise the test pattern source.
module tb_vga_scan_fetch;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 4,  VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int PIXW = 4, WORDW = 16, AW = 8, LAT = 3;
  localparam int PPW = WORDW / PIXW;

  logic              vid_clk = 1'b0;
  logic              vid_rst = 1'b1;
  logic [AW-1:0]     frame_base = '0;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [WORDW-1:0]  mem_data;
  logic [PIXW-1:0]   pixel;
  logic              hsync, vsync, vid_blank, oddeven, frame_start;
`ifdef VGA_SCAN_TESTPAT_EN
  logic              testpat_sel = 1'b0;
`endif

  int            n_pass  = 0;
  int            n_total = 0;
  int            n_fail  = 0;
  bit            tp_mode = 1'b0;
  logic [AW-1:0] run_base [2];

  // clock / reset
  always #5 vid_clk = ~vid_clk;

  vga_scan_fetch #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .PIX_W(PIXW), .WORD_W(WORDW), .ADDR_W(AW), .MEM_LAT(LAT)
  ) dut (
    .vid_clk     (vid_clk),
    .vid_rst     (vid_rst),
    .frame_base  (frame_base),
`ifdef VGA_SCAN_TESTPAT_EN
    .testpat_sel (testpat_sel),
`endif
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .pixel       (pixel),
    .hsync       (hsync),
    .vsync       (vsync),
    .vid_blank   (vid_blank),
    .oddeven     (oddeven),
    .frame_start (frame_start)
  );

  function automatic logic [WORDW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, a ^ 8'hA5};
  endfunction

  function automatic logic [PIXW-1:0] nib(input logic [AW-1:0] a, input int k);
    logic [WORDW-1:0] w;
    w = mem_word(a) >> (k * PIXW);
    return w[PIXW-1:0];
  endfunction

  function automatic logic [AW-1:0] addr_of(input int n, input int h, input int v);
    return AW'(int'(run_base[n]) + v * (HA / PPW) + h / PPW);
  endfunction

  // memory model: data valid LAT clocks after the read, garbage otherwise
  logic [LAT-1:0] rd_pipe = '0;
  logic [AW-1:0]  addr_pipe [LAT];
  always @(posedge vid_clk) begin
    rd_pipe      <= {rd_pipe[LAT-2:0], mem_rd};
    addr_pipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign mem_data = rd_pipe[LAT-1] ? mem_word(addr_pipe[LAT-1]) : 16'hBEEF;

  // scoreboard
  task automatic check(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string pfx, input int c);
    check({pfx, "_pixel"}, c, 32'(pixel), 32'h0);
    check({pfx, "_blank"}, c, 32'(vid_blank), 32'h0);
    check({pfx, "_hsync"}, c, 32'(hsync), 32'h1);
    check({pfx, "_vsync"}, c, 32'(vsync), 32'h1);
    check({pfx, "_odd"}, c, 32'(oddeven), 32'h0);
    check({pfx, "_fstart"}, c, 32'(frame_start), 32'h0);
  endtask

  task automatic check_reset(input int c);
    check("rst_mem_rd", c, 32'(mem_rd), 32'h0);
    check("rst_mem_addr", c, 32'(mem_addr), 32'h0);
    check_idle_outputs("rst", c);
  endtask

  // c = cycles since the first edge after reset release (fetch position c)
  task automatic check_cycle(input int c);
    int h, v, p, ho, vo, no;
    logic exp_rd, act;
    logic [PIXW-1:0] exp_px;
    h = c % HT;
    v = (c / HT) % VT;
    exp_rd = (h < HA) && (v < VA) && (h % PPW == 0) && !tp_mode;
    check("mem_rd", c, 32'(mem_rd), 32'(exp_rd));
    if (exp_rd) check("mem_addr", c, 32'(mem_addr), 32'(addr_of(c / FT, h, v)));
    if (c < LAT + 1) begin
      check_idle_outputs("lead", c);
    end else begin
      p  = c - (LAT + 1);
      ho = p % HT;
      vo = (p / HT) % VT;
      no = p / FT;
      act = (ho < HA) && (vo < VA);
      exp_px = '0;
      if (act) exp_px = tp_mode ? PIXW'(ho ^ vo) : nib(addr_of(no, ho, vo), ho % PPW);
      check("pixel", c, 32'(pixel), 32'(exp_px));
      check("blank", c, 32'(vid_blank), 32'(act));
      check("hsync", c, 32'(hsync), 32'(!(ho >= HA + HFP && ho < HA + HFP + HS)));
      check("vsync", c, 32'(vsync), 32'(!(vo >= VA + VFP && vo < VA + VFP + VS)));
      check("oddeven", c, 32'(oddeven), 32'(vo % 2));
      check("fstart", c, 32'(frame_start), 32'(ho == 0 && vo == 0));
    end
  endtask

  initial begin
    // reset held for 5 clocks
    vid_rst    = 1'b1;
    frame_base = 8'hF8;
    repeat (5) @(negedge vid_clk);
    check_reset(-1);

    // run 1: base 0xF8 wraps past 0xFF; base switched to 0x40 mid-frame
    run_base[0] = 8'hF8;
    run_base[1] = 8'h40;
    vid_rst = 1'b0;
    for (int c = 0; c <= 250; c++) begin
      @(negedge vid_clk);
      check_cycle(c);
      case (c)
        0:   check("first_addr", c, 32'(mem_addr), 32'hF8);
        4:   check("px_hand0", c, 32'(pixel), 32'hD);
        5:   check("px_hand1", c, 32'(pixel), 32'h5);
        6:   check("px_hand2", c, 32'(pixel), 32'h8);
        7:   check("px_hand3", c, 32'(pixel), 32'hF);
        48:  check("wrap_addr", c, 32'(mem_addr), 32'h00);
        192: check("dbuf_addr", c, 32'(mem_addr), 32'h40);
        196: check("fstart_period", c, 32'(frame_start), 32'h1);
        default: ;
      endcase
      if (c == 50) frame_base = 8'h40;
    end

    // mid-frame reset at h=10, v=2 held for 3 clocks
    vid_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge vid_clk);
      check_reset(300 + i);
    end

    // run 2: restart from frame_base
    run_base[0] = 8'h40;
    run_base[1] = 8'h40;
`ifdef VGA_SCAN_TESTPAT_EN
    testpat_sel = 1'b1;
    tp_mode     = 1'b1;
`endif
    vid_rst = 1'b0;
    for (int c = 0; c <= 200; c++) begin
      @(negedge vid_clk);
      check_cycle(c);
      case (c)
        4: check("restart_fstart", c, 32'(frame_start), 32'h1);
`ifdef VGA_SCAN_TESTPAT_EN
        81: check("tp_pix_5_3", c, 32'(pixel), 32'h6);
`else
        0: check("restart_addr", c, 32'(mem_addr), 32'h40);
`endif
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
